// File: rtl/ddfs_div_pkg.sv
// Shared constants for the DDFS programmable clock divider.
// Holds the reset ratio, the mode encoding and the decade table generator.
package ddfs_div_pkg;

   localparam int unsigned RST_DIV = 2;

   typedef enum logic {
      MODE_DECADE = 1'b0,
      MODE_PROG   = 1'b1
   } ddfs_mode_e;

   // 2 for k=0, 10^k otherwise, saturated to 2^cnt_w-1.
   function automatic longint unsigned decade_ratio(input int unsigned k,
                                                    input int unsigned cnt_w);
      longint unsigned maxv;
      longint unsigned r;
      maxv = (64'd1 << cnt_w) - 64'd1;
      if (k == 0) begin
         r = 64'(RST_DIV);
      end else begin
         r = 64'd1;
         for (int unsigned i = 0; i < k; i++) begin
            r = r * 64'd10;
            if (r > maxv) r = maxv;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/ddfs_div_ratio_sel.sv
// Requested-ratio selection: decade table lookup (index clamped to the last
// entry) or programmed ratio (0 and 1 clamped to 2).
module ddfs_div_ratio_sel
   import ddfs_div_pkg::*;
#(
   parameter int unsigned CNT_W   = 20,
   parameter int unsigned NUM_SEL = 7,
   parameter int unsigned SEL_W   = 3
) (
   input  logic [SEL_W-1:0] freq_cntrl_i,
   input  logic             mode_i,
   input  logic [CNT_W-1:0] div_in_i,
   output logic [CNT_W-1:0] req_o
);

   logic [CNT_W-1:0] decade_tbl [NUM_SEL];

   for (genvar g = 0; g < NUM_SEL; g++) begin : g_tbl
      localparam logic [CNT_W-1:0] RATIO = CNT_W'(decade_ratio(g, CNT_W));
      assign decade_tbl[g] = RATIO;
   end

   // Select the requested ratio from the active source.
   always_comb begin
      req_o = decade_tbl[NUM_SEL-1];
      if (ddfs_mode_e'(mode_i) == MODE_PROG) begin
         req_o = (div_in_i < CNT_W'(2)) ? CNT_W'(RST_DIV) : div_in_i;
      end else begin
         for (int unsigned i = 0; i < NUM_SEL; i++) begin
            if (32'(freq_cntrl_i) == i) req_o = decade_tbl[i];
         end
      end
   end

endmodule

// File: rtl/ddfs_prog_clk_div.sv
// DDFS programmable clock divider: decade or programmed ratio, registered
// near-50% clk_out, one-cycle tick, glitch-free ratio update at period
// boundaries with forced restart.
// Optional: define DDFS_DIV_SYNC_EN to pass the control inputs through
// 2-flop synchronisers.
module ddfs_prog_clk_div
   import ddfs_div_pkg::*;
#(
   parameter int unsigned CNT_W   = 20,
   parameter int unsigned NUM_SEL = 7,
   parameter int unsigned SEL_W   = 3
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic [SEL_W-1:0] freq_cntrl,
   input  logic             mode,
   input  logic [CNT_W-1:0] div_in,
   input  logic             restart,
   output logic             clk_out,
   output logic             tick,
   output logic             pending,
   output logic [CNT_W-1:0] div_act
);

   logic [SEL_W-1:0] freq_s;
   logic             mode_s;
   logic [CNT_W-1:0] div_in_s;
   logic             restart_s;

`ifdef DDFS_DIV_SYNC_EN
   logic [SEL_W-1:0] freq_s1_q, freq_s2_q;
   logic             mode_s1_q, mode_s2_q;
   logic [CNT_W-1:0] div_s1_q, div_s2_q;
   logic             rst_s1_q, rst_s2_q;

   // Two-stage synchronisers on all control inputs.
   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         freq_s1_q <= '0;
         freq_s2_q <= '0;
         mode_s1_q <= 1'b0;
         mode_s2_q <= 1'b0;
         div_s1_q  <= '0;
         div_s2_q  <= '0;
         rst_s1_q  <= 1'b0;
         rst_s2_q  <= 1'b0;
      end else begin
         freq_s1_q <= freq_cntrl;
         freq_s2_q <= freq_s1_q;
         mode_s1_q <= mode;
         mode_s2_q <= mode_s1_q;
         div_s1_q  <= div_in;
         div_s2_q  <= div_s1_q;
         rst_s1_q  <= restart;
         rst_s2_q  <= rst_s1_q;
      end
   end

   assign freq_s    = freq_s2_q;
   assign mode_s    = mode_s2_q;
   assign div_in_s  = div_s2_q;
   assign restart_s = rst_s2_q;
`else
   assign freq_s    = freq_cntrl;
   assign mode_s    = mode;
   assign div_in_s  = div_in;
   assign restart_s = restart;
`endif

   logic [CNT_W-1:0] req;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] div_q, div_d;
   logic             clk_q, clk_d;
   logic             tick_q, tick_d;
   logic             pend_q, pend_d;
   logic [CNT_W:0]   half;

   ddfs_div_ratio_sel #(
      .CNT_W   (CNT_W),
      .NUM_SEL (NUM_SEL),
      .SEL_W   (SEL_W)
   ) u_ratio_sel (
      .freq_cntrl_i (freq_s),
      .mode_i       (mode_s),
      .div_in_i     (div_in_s),
      .req_o        (req)
   );

   // Next-state: boundary reload or count; outputs derived from next state
   // so clk_out/tick/pending are pure flop outputs.
   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      div_d = div_q;
      if ((cnt_q == div_q - CNT_W'(1)) || restart_s) begin
         cnt_d = '0;
         div_d = req;
      end
      half   = ({1'b0, div_d} + (CNT_W+1)'(1)) >> 1;
      clk_d  = ({1'b0, cnt_d} < half);
      tick_d = (cnt_d == '0);
      pend_d = (req != div_d);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         cnt_q  <= CNT_W'(1);
         div_q  <= CNT_W'(RST_DIV);
         clk_q  <= 1'b0;
         tick_q <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         div_q  <= div_d;
         clk_q  <= clk_d;
         tick_q <= tick_d;
         pend_q <= pend_d;
      end
   end

   assign clk_out = clk_q;
   assign tick    = tick_q;
   assign pending = pend_q;
   assign div_act = div_q;

endmodule

// File: tb/tb_ddfs_prog_clk_div.sv
// Self-checking bench for ddfs_prog_clk_div: a period-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_ddfs_prog_clk_div;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  freq_cntrl;
   logic        mode;
   logic [19:0] div_in;
   logic        restart;
   logic        clk_out, tick, pending;
   logic [19:0] div_act;

   logic        clk_out2, tick2, pending2;
   logic [15:0] div_act2;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ddfs_prog_clk_div dut (
      .clk_in(clk), .rst_n(rst_n), .freq_cntrl(freq_cntrl), .mode(mode),
      .div_in(div_in), .restart(restart), .clk_out(clk_out), .tick(tick),
      .pending(pending), .div_act(div_act)
   );

   ddfs_prog_clk_div #(.CNT_W(16), .NUM_SEL(7), .SEL_W(3)) dut16 (
      .clk_in(clk), .rst_n(rst_n), .freq_cntrl(3'd6), .mode(1'b0),
      .div_in(16'd0), .restart(1'b0), .clk_out(clk_out2), .tick(tick2),
      .pending(pending2), .div_act(div_act2)
   );

   task automatic chk(input string name, input longint unsigned act,
                      input longint unsigned exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Requested ratio straight from the selection rules.
   function automatic longint unsigned m_req(input bit md, input int unsigned fc,
                                             input longint unsigned di,
                                             input int unsigned cw);
      longint unsigned maxv, r;
      int unsigned k;
      maxv = (64'd1 << cw) - 64'd1;
      if (md) return (di < 2) ? 64'd2 : di;
      k = (fc >= 7) ? 6 : fc;
      if (k == 0) return 64'd2;
      r = 1;
      repeat (k) r = r * 10;
      return (r > maxv) ? maxv : r;
   endfunction

   // Reference model: position within the current period and active ratio.
   longint unsigned m_pos, m_div, r_req, e_di;
   bit              m_clk, m_tick, m_pend, e_md, e_rs;
   int unsigned     e_fc;
   bit              model_valid = 0;
   int unsigned     p1_fc, p2_fc;
   bit              p1_md, p2_md, p1_rs, p2_rs;
   longint unsigned p1_di, p2_di;

   always @(posedge clk) begin
`ifdef DDFS_DIV_SYNC_EN
      e_fc = p2_fc; e_md = p2_md; e_di = p2_di; e_rs = p2_rs;
      if (!rst_n) begin
         p1_fc = 0; p2_fc = 0; p1_md = 0; p2_md = 0;
         p1_di = 0; p2_di = 0; p1_rs = 0; p2_rs = 0;
      end else begin
         p2_fc = p1_fc; p2_md = p1_md; p2_di = p1_di; p2_rs = p1_rs;
         p1_fc = freq_cntrl; p1_md = mode; p1_di = div_in; p1_rs = restart;
      end
`else
      e_fc = freq_cntrl; e_md = mode; e_di = div_in; e_rs = restart;
`endif
      if (!rst_n) begin
         m_pos = 1; m_div = 2; m_clk = 0; m_tick = 0; m_pend = 0;
      end else begin
         r_req = m_req(e_md, e_fc, e_di, 20);
         if (m_pos + 1 == m_div || e_rs) begin
            m_pos = 0;
            m_div = r_req;
         end else begin
            m_pos = m_pos + 1;
         end
         m_clk  = (2 * m_pos < m_div);
         m_tick = (m_pos == 0);
         m_pend = (r_req != m_div);
      end
      model_valid = 1;
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (model_valid) begin
         chk("model_clk_out", clk_out, m_clk);
         chk("model_tick", tick, m_tick);
         chk("model_pending", pending, m_pend);
         chk("model_div_act", div_act, m_div);
      end
   end

   int hi, tk, lat;

   initial begin
      rst_n = 0; freq_cntrl = 0; mode = 0; div_in = 0; restart = 0;
      step(3);
      chk("rst_clk_out", clk_out, 0);
      chk("rst_tick", tick, 0);
      chk("rst_pending", pending, 0);
      chk("rst_div_act", div_act, 2);
      chk("rst_div_act16", div_act2, 2);
`ifndef DDFS_DIV_SYNC_EN
      // Ratio 2 after reset: first edge is a boundary.
      rst_n = 1;
      step(1);
      chk("r2_tick0", tick, 1);
      chk("r2_clk0", clk_out, 1);
      chk("r2_div", div_act, 2);
      chk("sat16_div", div_act2, 65535);
      step(1);
      chk("r2_tick1", tick, 0);
      chk("r2_clk1", clk_out, 0);
      step(1);
      chk("r2_tick2", tick, 1);
      chk("r2_clk2", clk_out, 1);

      // Ratio 1000 from reset.
      rst_n = 0; freq_cntrl = 3;
      step(2);
      rst_n = 1;
      step(1);
      chk("r1000_tick", tick, 1);
      chk("r1000_div", div_act, 1000);
      hi = clk_out; tk = 0;
      for (int i = 0; i < 999; i++) begin
         step(1);
         hi += clk_out;
         tk += tick;
      end
      chk("r1000_high", hi, 500);
      chk("r1000_ticks_inside", tk, 0);
      step(1);
      chk("r1000_period_tick", tick, 1);

      // Mid-period switch to ratio 10 at cnt=200.
      step(200);
      freq_cntrl = 1;
      step(1);
      chk("sw_pending", pending, 1);
      chk("sw_div_hold", div_act, 1000);
      step(798);
      chk("sw_div_at999", div_act, 1000);
      chk("sw_pending_at999", pending, 1);
      step(1);
      chk("sw_div_new", div_act, 10);
      chk("sw_pending_clr", pending, 0);
      chk("sw_tick", tick, 1);

      // Forced restart at cnt=200.
      freq_cntrl = 3; restart = 1;
      step(1);
      restart = 0;
      chk("rs_div1000", div_act, 1000);
      step(200);
      freq_cntrl = 1; restart = 1;
      step(1);
      restart = 0;
      chk("rs_tick", tick, 1);
      chk("rs_div10", div_act, 10);
      chk("rs_clk", clk_out, 1);

      // Programmed ratios.
      mode = 1; div_in = 7; restart = 1;
      step(1);
      restart = 0;
      chk("p7_div", div_act, 7);
      hi = clk_out;
      for (int i = 0; i < 6; i++) begin
         step(1);
         hi += clk_out;
      end
      chk("p7_high", hi, 4);
      step(1);
      chk("p7_tick", tick, 1);
      div_in = 0; restart = 1;
      step(1);
      chk("p0_div", div_act, 2);
      div_in = 1;
      step(1);
      chk("p1_div", div_act, 2);
      restart = 0;

      // Out-of-range select clamps to the last entry.
      mode = 0; freq_cntrl = 7; restart = 1;
      step(1);
      restart = 0;
      chk("sel7_div", div_act, 1000000);
      step(5);
      chk("sel7_pending", pending, 0);

      // Reset mid-period.
      rst_n = 0;
      step(1);
      chk("mrst_clk", clk_out, 0);
      chk("mrst_tick", tick, 0);
      chk("mrst_pending", pending, 0);
      chk("mrst_div", div_act, 2);
      rst_n = 1;
      step(1);
      chk("mrst_restart_tick", tick, 1);
      chk("mrst_restart_div", div_act, 1000000);
      freq_cntrl = 0; restart = 1;
      step(1);
      restart = 0;
      step(6);
`else
      // Synchronised controls: pending follows an input change by 3 edges.
      freq_cntrl = 3;
      rst_n = 1;
      step(20);
      lat = 0;
      while (!tick && lat < 2000) begin
         step(1);
         lat++;
      end
      chk("sync_tick_seen", tick, 1);
      step(100);
      freq_cntrl = 1;
      lat = 0;
      while (!pending && lat < 10) begin
         step(1);
         lat++;
      end
      chk("sync_pending_latency", lat, 3);
      step(10);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
